// File: rtl/pp_pkg.sv
// Shared types and default sizing for the spectrum post-processing chain.
package pp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DEDUCT  = 2'd2
    } pp_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NBINS  = 512;
    localparam int DEF_ADDR_W = 9;

endpackage

// File: rtl/bg_ram.sv
// Background spectrum store: simple dual-port RAM, one write port and one
// synchronous read port with a single cycle of read latency.
module bg_ram
    import pp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NBINS  = DEF_NBINS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [NBINS];
    logic [DATA_W-1:0] rdata_r;

    // Write port; the array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/bg_subtract_pipe.sv
// Background capture and bin-wise saturating subtraction of streamed spectra.
// FSM and bin counter issue RAM accesses; a 2-stage pipeline produces dout.
module bg_subtract_pipe
    import pp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NBINS  = DEF_NBINS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bg_capture_en,
    input  logic              bg_deduct_en,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic              frame_done,
    output logic              bg_ready,
    output logic              bg_missing
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    pp_state_e         state_r, state_next_s;
    logic [ADDR_W-1:0] bin_cnt_r, bin_cnt_next_s;
    logic              bg_ready_r, bg_ready_next_s;
    logic              bg_missing_r, bg_missing_next_s;
    logic              ram_we_s, issue_s, is_last_s;

    logic              s0_valid_r, s0_last_r, s0_bg_ok_r;
    logic [DATA_W-1:0] s0_din_r;
    logic [DATA_W-1:0] ram_rdata_s, bg_val_s, result_s;

    logic              dout_valid_r, frame_done_r;
    logic [DATA_W-1:0] dout_r;

    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = '0;
        end
        return r;
    endfunction

    assign is_last_s = (bin_cnt_r == LAST_BIN);

    // Mode sequencing, bin counting and flag updates.
    always_comb begin
        state_next_s      = state_r;
        bin_cnt_next_s    = bin_cnt_r;
        bg_ready_next_s   = bg_ready_r;
        bg_missing_next_s = bg_missing_r;
        ram_we_s          = 1'b0;
        issue_s           = 1'b0;
        case (state_r)
            IDLE: begin
                bin_cnt_next_s = '0;
                if (bg_capture_en) begin
                    state_next_s      = CAPTURE;
                    bg_ready_next_s   = 1'b0;
                    bg_missing_next_s = 1'b0;
                end else if (bg_deduct_en) begin
                    state_next_s = DEDUCT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CAPTURE: begin
                if (!bg_capture_en) begin
                    state_next_s   = IDLE;
                    bin_cnt_next_s = '0;
                end else if (din_valid) begin
                    ram_we_s = 1'b1;
                    if (is_last_s) begin
                        bg_ready_next_s = 1'b1;
                        bin_cnt_next_s  = '0;
                        state_next_s    = IDLE;
                    end else begin
                        bin_cnt_next_s = bin_cnt_r + CNT_ONE;
                    end
                end else begin
                    bin_cnt_next_s = bin_cnt_r;
                end
            end
            DEDUCT: begin
                if (!bg_deduct_en) begin
                    state_next_s   = IDLE;
                    bin_cnt_next_s = '0;
                end else if (din_valid) begin
                    issue_s = 1'b1;
                    if (!bg_ready_r) begin
                        bg_missing_next_s = 1'b1;
                    end else begin
                        bg_missing_next_s = bg_missing_r;
                    end
                    if (is_last_s) begin
                        bin_cnt_next_s = '0;
                    end else begin
                        bin_cnt_next_s = bin_cnt_r + CNT_ONE;
                    end
                end else begin
                    bin_cnt_next_s = bin_cnt_r;
                end
            end
            default: begin
                state_next_s   = IDLE;
                bin_cnt_next_s = '0;
            end
        endcase
    end

    // Control state and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            bin_cnt_r    <= '0;
            bg_ready_r   <= 1'b0;
            bg_missing_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            bin_cnt_r    <= bin_cnt_next_s;
            bg_ready_r   <= bg_ready_next_s;
            bg_missing_r <= bg_missing_next_s;
        end
    end

    bg_ram #(
        .DATA_W (DATA_W),
        .NBINS  (NBINS),
        .ADDR_W (ADDR_W)
    ) u_bg_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (bin_cnt_r),
        .wdata (din),
        .re    (issue_s),
        .raddr (bin_cnt_r),
        .rdata (ram_rdata_s)
    );

    // Stage 0: hold the sample alongside the RAM read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s0_last_r  <= 1'b0;
            s0_bg_ok_r <= 1'b0;
            s0_din_r   <= '0;
        end else begin
            s0_valid_r <= issue_s;
            s0_last_r  <= issue_s & is_last_s;
            if (issue_s) begin
                s0_bg_ok_r <= bg_ready_r;
                s0_din_r   <= din;
            end else begin
                s0_bg_ok_r <= s0_bg_ok_r;
                s0_din_r   <= s0_din_r;
            end
        end
    end

    // Without a complete background the RAM word is garbage; treat it as zero.
    assign bg_val_s = s0_bg_ok_r ? ram_rdata_s : '0;
    assign result_s = sat_sub(s0_din_r, bg_val_s);

    // Stage 1: registered result and frame marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            dout_r       <= '0;
        end else begin
            dout_valid_r <= s0_valid_r;
            frame_done_r <= s0_valid_r & s0_last_r;
            if (s0_valid_r) begin
                dout_r <= result_s;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign dout_valid = dout_valid_r;
    assign dout       = dout_r;
    assign frame_done = frame_done_r;
    assign bg_ready   = bg_ready_r;
    assign bg_missing = bg_missing_r;

endmodule

// File: tb/tb_bg_subtract_pipe.sv
// Randomised scoreboard bench for bg_subtract_pipe with NBINS = 4.
module tb_bg_subtract_pipe;

    localparam int DW = 32;
    localparam int NB = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          bg_capture_en;
    logic          bg_deduct_en;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          dout_valid;
    logic [DW-1:0] dout;
    logic          frame_done;
    logic          bg_ready;
    logic          bg_missing;

    bg_subtract_pipe #(.DATA_W(DW), .NBINS(NB), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bg_capture_en (bg_capture_en),
        .bg_deduct_en  (bg_deduct_en),
        .din_valid     (din_valid),
        .din           (din),
        .dout_valid    (dout_valid),
        .dout          (dout),
        .frame_done    (frame_done),
        .bg_ready      (bg_ready),
        .bg_missing    (bg_missing)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint unsigned data;
        bit              last;
        int              t;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    // Reference model state: background contents and flags as the spec defines them.
    longint unsigned bg_m[NB];
    bit m_ready;
    bit m_missing;
    int m_idx;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic enter_capture();
        bg_capture_en = 1'b1;
        bg_deduct_en  = 1'b0;
        tick();
        m_ready   = 1'b0;
        m_missing = 1'b0;
        m_idx     = 0;
    endtask

    task automatic enter_deduct();
        bg_deduct_en = 1'b1;
        tick();
        m_idx = 0;
    endtask

    task automatic leave();
        din_valid     = 1'b0;
        bg_capture_en = 1'b0;
        bg_deduct_en  = 1'b0;
        tick();
        m_idx = 0;
    endtask

    task automatic capture_bin(input longint unsigned d, input int gap);
        idle_gap(gap);
        din_valid = 1'b1;
        din       = d[DW-1:0];
        tick();
        din_valid = 1'b0;
        bg_m[m_idx] = d;
        m_idx++;
        if (m_idx == NB) begin
            m_ready = 1'b1;
            m_idx   = 0;
        end
    endtask

    task automatic deduct_bin(input longint unsigned d, input int gap);
        exp_t e;
        idle_gap(gap);
        din_valid = 1'b1;
        din       = d[DW-1:0];
        tick();
        din_valid = 1'b0;
        if (m_ready) e.data = (d >= bg_m[m_idx]) ? d - bg_m[m_idx] : 64'd0;
        else begin
            e.data    = d;
            m_missing = 1'b1;
        end
        e.last = (m_idx == NB - 1);
        e.t    = cyc;
        q.push_back(e);
        m_idx = (m_idx + 1) % NB;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_bg_ready"}, bg_ready, m_ready);
        check({tag, "_bg_missing"}, bg_missing, m_missing);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("queue_drained", q.size(), 0);
    endtask

    // Monitor: every presented output bin is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dout_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: dout_valid=1 dout=%0d, expected no output", dout);
                end else begin
                    e = q.pop_front();
                    check("dout", dout, e.data);
                    check("frame_done", frame_done, e.last);
                    check("latency", cyc, e.t + 1);
                end
            end else if (frame_done) begin
                checks++;
                $display("FAIL frame_done_alone: frame_done=1 with dout_valid=0, expected 0");
            end
        end
    end

    initial begin
        longint unsigned d;
        rst = 1'b1;
        bg_capture_en = 1'b0;
        bg_deduct_en  = 1'b0;
        din_valid = 1'b0;
        din = '0;
        m_ready = 1'b0;
        m_missing = 1'b0;
        m_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check_flags("rst");
        rst = 1'b0;
        tick();

        // Deduct with no background: passthrough and sticky missing flag.
        enter_deduct();
        deduct_bin(123, 0);
        deduct_bin(64'(32'hFFFF_FFFF), 0);
        leave();
        check_flags("nobg");
        drain();

        enter_capture();
        check_flags("cap_entry");
        capture_bin(10, 0);
        capture_bin(20, 0);
        capture_bin(30, 0);
        capture_bin(40, 0);
        leave();
        check_flags("cap_done");

        // Directed frame, then a clamp frame (7 - 40 -> 0), then random gapped frames.
        enter_deduct();
        deduct_bin(15, 0);
        deduct_bin(20, 0);
        deduct_bin(35, 0);
        deduct_bin(100, 0);
        deduct_bin(1, 0);
        deduct_bin(2, 1);
        deduct_bin(3, 0);
        deduct_bin(7, 2);
        for (int i = 0; i < 3 * NB; i++) deduct_bin($urandom_range(0, 80), $urandom_range(0, 3));
        check_flags("deduct");

        // Drop the enable after bin 1; re-entry restarts at bg[0].
        deduct_bin($urandom_range(0, 80), 0);
        deduct_bin($urandom_range(0, 80), 0);
        leave();
        enter_deduct();
        for (int i = 0; i < NB + 1; i++) deduct_bin($urandom_range(0, 80), $urandom_range(0, 2));
        leave();
        drain();

        // Random background with gaps, full-range data.
        enter_capture();
        for (int i = 0; i < NB; i++) capture_bin(64'($urandom()), $urandom_range(0, 3));
        leave();
        check_flags("cap2");
        enter_deduct();
        for (int i = 0; i < 2 * NB; i++) begin
            d = 64'($urandom());
            deduct_bin(d, $urandom_range(0, 3));
        end
        leave();
        drain();

        // Asynchronous reset in the middle of a capture.
        enter_capture();
        capture_bin(5, 0);
        capture_bin(6, 0);
        #2;
        rst = 1'b1;
        bg_capture_en = 1'b0;
        #1;
        q.delete();
        m_ready = 1'b0;
        m_missing = 1'b0;
        m_idx = 0;
        check("arst_dout", dout, 0);
        check("arst_dout_valid", dout_valid, 0);
        check_flags("arst");
        tick();
        rst = 1'b0;
        idle_gap(3);
        check_flags("post_rst");
        enter_capture();
        for (int i = 0; i < NB - 1; i++) capture_bin(64'($urandom_range(0, 50)), 0);
        leave();
        check_flags("partial_cap");
        enter_deduct();
        deduct_bin(77, 0);
        leave();
        check_flags("partial_deduct");
        drain();
        enter_capture();
        for (int i = 0; i < NB; i++) capture_bin(64'($urandom_range(0, 50)), $urandom_range(0, 1));
        leave();
        check_flags("recap");
        enter_deduct();
        for (int i = 0; i < NB; i++) deduct_bin($urandom_range(0, 100), 0);
        leave();
        drain();
        idle_gap(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
